avm_read_master: RTL and testbench

AVM_READ_MASTER -- requirements
Module: avm_read_master

---
 rtl/avm_read_master.sv | 120 ++++++++++++
 tb/tb_avm_read_master.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avm_read_master.sv
// avm_read_master: Avalon-MM burst-less read master feeding an Avalon-ST sink
// through a first-word-fall-through response FIFO. Reads are credit-limited so
// the FIFO can never overflow.
// Build option: define AVM_RD_PIPELINE_EN to allow up to 4 reads in flight;
// otherwise each read waits for its response before the next one issues.
module avm_read_master #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        aclr,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] word_count,
    output logic        busy,
    output logic        done,
    output logic [31:0] avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic [31:0] st_data,
    output logic        st_valid,
    input  logic        st_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
`ifdef AVM_RD_PIPELINE_EN
    localparam int MAX_OUT = 4;
`else
    localparam int MAX_OUT = 1;
`endif

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [31:0]     addr_q;
    logic [15:0]     remaining_q;
    logic [CW-1:0]   out_q;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [31:0]     mem [FIFO_DEPTH];
    logic            done_q;

    logic            accept, zero_cmd, credit, issue, push, pop, drained;

    // Credit: words in flight plus words buffered must leave room in the FIFO.
    // Both terms only shrink during a stall, so avm_read stays asserted.
    always_comb begin
        accept   = (state == IDLE) && start && (word_count != 16'd0);
        zero_cmd = (state == IDLE) && start && (word_count == 16'd0);
        credit   = (({1'b0, out_q} + {1'b0, cnt_q}) < (CW+1)'(FIFO_DEPTH)) &&
                   (out_q < CW'(MAX_OUT));
        issue    = avm_read && !avm_waitrequest;
        push     = avm_readdatavalid && (state != IDLE);
        pop      = st_valid && st_ready;
        drained  = (state == DRAIN) && (out_q == '0) && (cnt_q == '0);
    end

    // State register
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = READ;
            READ:    if (issue && (remaining_q == 16'd1)) state_nxt = DRAIN;
            DRAIN:   if (drained) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state and FIFO level
    always_comb begin
        busy        = (state != IDLE);
        done        = done_q;
        avm_read    = (state == READ) && credit;
        avm_address = addr_q;
        st_valid    = (cnt_q != '0);
        st_data     = st_valid ? mem[rd_ptr] : 32'd0;
    end

    // Command latch, address walk, outstanding/level counters, done pulse
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            addr_q      <= 32'd0;
            remaining_q <= 16'd0;
            out_q       <= '0;
            cnt_q       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= zero_cmd || drained;
            if (accept) begin
                addr_q      <= base_addr & 32'hFFFF_FFFC;
                remaining_q <= word_count;
            end else if (issue) begin
                addr_q      <= addr_q + 32'd4;
                remaining_q <= remaining_q - 16'd1;
            end
            if (issue && !push)      out_q <= out_q + CW'(1);
            else if (!issue && push) out_q <= out_q - CW'(1);
            if (push && !pop)        cnt_q <= cnt_q + CW'(1);
            else if (!push && pop)   cnt_q <= cnt_q - CW'(1);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // FIFO storage; contents need no reset since the level gates st_data
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= avm_readdata;
    end

endmodule

// File: tb/tb_avm_read_master.sv
// Bench for avm_read_master: memory slave model with configurable latency and
// stalls, plus an address/data reference derived from base + 4*i ordering.
module tb_avm_read_master;

    localparam int DEPTH = 8;
`ifdef AVM_RD_PIPELINE_EN
    localparam int MAX_OUT = 4;
`else
    localparam int MAX_OUT = 1;
`endif

    logic        clk = 1'b0;
    logic        aclr;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic        busy, done;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic [31:0] st_data;
    logic        st_valid;
    logic        st_ready;

    avm_read_master #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .aclr(aclr), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy), .done(done),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .st_data(st_data),
        .st_valid(st_valid), .st_ready(st_ready)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    logic [31:0] salt;

    // slave / environment controls
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          last_due = 0;
    int          lat_mode = 0;      // 0: fixed 2, 1: random 1..4, 2: fixed 4
    int          wr_mode = 0;       // 0: never stall, 1: random stalls
    int          stall_on_idx = -1;
    int          stall_left = 0;
    int          ready_mode = 1;    // 0: never, 1: always, 2: random

    // reference / scoreboard state
    logic [31:0] exp_addr = 32'd0;
    logic [31:0] exp_words[$];
    logic [31:0] issue_log[$];
    int          issued = 0;
    int          done_cnt = 0;
    int          reads_seen = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = 32'd0;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Slave: in-order responses after a latency, optional stalls; sink ready
    always @(posedge clk) begin
        int n;
        cyc++;
        #1;
        if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = mem_word(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = $urandom;
        end
        if (stall_on_idx >= 0 && issued == stall_on_idx && avm_read && stall_left > 0) begin
            avm_waitrequest = 1'b1;
            stall_left--;
        end else if (wr_mode == 1) avm_waitrequest = ($urandom_range(2) == 0);
        else                       avm_waitrequest = 1'b0;
        n = 0;
        case (ready_mode)
            0:       st_ready = 1'b0;
            1:       st_ready = 1'b1;
            default: st_ready = ($urandom_range(1) == 1);
        endcase
    end

    // Monitor: sampled mid-cycle, events take effect at the next rising edge
    always @(negedge clk) begin
        int d;
        if (!aclr) begin
            if (prev_stall) begin
                chk("stall_read_held", 32'(avm_read), 32'd1);
                chk("stall_addr_held", avm_address, prev_addr);
            end
            prev_stall = avm_read && avm_waitrequest;
            prev_addr  = avm_address;
            if (avm_read) reads_seen++;
            if (avm_read && !avm_waitrequest) begin
                chk("issue_addr", avm_address, exp_addr);
                chk("credit_fifo", 32'(exp_words.size() < DEPTH), 32'd1);
                chk("credit_out", 32'(pend_addr.size() < MAX_OUT), 32'd1);
                case (lat_mode)
                    0:       d = cyc + 2;
                    1:       d = cyc + int'($urandom_range(4, 1));
                    default: d = cyc + 4;
                endcase
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                pend_addr.push_back(avm_address);
                pend_due.push_back(d);
                exp_words.push_back(mem_word(exp_addr));
                issue_log.push_back(avm_address);
                exp_addr = exp_addr + 32'd4;
                issued++;
            end
            if (st_valid && st_ready) begin
                if (exp_words.size() == 0) chk("spurious_word", 32'(st_valid), 32'd0);
                else chk("st_data", st_data, exp_words.pop_front());
            end
            if (done) begin
                chk("busy_at_done", 32'(busy), 32'd0);
                done_cnt++;
            end
        end
    end

    task automatic start_xfer(logic [31:0] b, logic [15:0] c);
        @(posedge clk); #1;
        base_addr  = b;
        word_count = c;
        start      = 1'b1;
        exp_addr   = b & 32'hFFFF_FFFC;
        issued     = 0;
        done_cnt   = 0;
        reads_seen = 0;
        issue_log.delete();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(string tag, int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk); n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done_once"}, 32'(done_cnt), 32'd1);
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    task automatic run(string tag, logic [31:0] b, logic [15:0] c, int budget);
        start_xfer(b, c);
        chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        wait_done(tag, budget);
        chk({tag, "_issued"}, 32'(issued), 32'(c));
        chk({tag, "_all_words_out"}, 32'(exp_words.size()), 32'd0);
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_avm_read"}, 32'(avm_read), 32'd0);
        chk({tag, "_st_valid"}, 32'(st_valid), 32'd0);
        chk({tag, "_avm_address"}, avm_address, 32'd0);
        chk({tag, "_st_data"}, st_data, 32'd0);
    endtask

    initial begin
        int n;
        salt              = $urandom;
        aclr              = 1'b1;
        start             = 1'b0;
        base_addr         = 32'd0;
        word_count        = 16'd0;
        avm_waitrequest   = 1'b0;
        avm_readdata      = 32'd0;
        avm_readdatavalid = 1'b0;
        st_ready          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        aclr = 1'b0;

        // basic 4-word read, fixed latency 2, no stalls
        run("basic", 32'h100, 16'd4, 200);
        for (int i = 0; i < 4; i++)
            chk("basic_addr_seq", issue_log[i], 32'h100 + 32'(4 * i));

        // 3-cycle stall on the second read
        stall_on_idx = 1; stall_left = 3;
        run("stall", 32'h200, 16'd4, 200);
        chk("stall_consumed", 32'(stall_left), 32'd0);
        stall_on_idx = -1;

        // sink blocked: no more than DEPTH words requested ahead
        ready_mode = 0;
        start_xfer(32'h1000, 16'd20);
        repeat (60) @(posedge clk);
        #1;
        chk("backpressure_issued", 32'(issued), 32'(DEPTH));
        chk("backpressure_st_valid", 32'(st_valid), 32'd1);
        chk("backpressure_busy", 32'(busy), 32'd1);
        ready_mode = 1;
        wait_done("backpressure", 500);
        chk("backpressure_total", 32'(issued), 32'd20);
        chk("backpressure_words", 32'(exp_words.size()), 32'd0);

        // zero-length command
        start_xfer(32'h800, 16'd0);
        chk("zero_done_next", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("zero_no_read", 32'(reads_seen), 32'd0);
        chk("zero_done_once", 32'(done_cnt), 32'd1);

        // start while busy is ignored
        start_xfer(32'h300, 16'd6);
        @(posedge clk); #1;
        base_addr = 32'h5000; word_count = 16'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("busy_start", 300);
        chk("busy_start_issued", 32'(issued), 32'd6);
        chk("busy_start_last_addr", issue_log[5], 32'h314);

        // reset mid-transfer with reads in flight
        lat_mode = 2;
        start_xfer(32'h400, 16'd8);
        n = 0;
        while (pend_addr.size() < ((MAX_OUT > 1) ? 2 : 1) && n < 200) begin
            @(posedge clk); n++;
        end
        @(posedge clk); #1;
        chk("midreset_inflight", 32'(pend_addr.size() > 0), 32'd1);
        aclr = 1'b1;
        #1;
        chk_all_zero("midreset");
        exp_words.delete();
        prev_stall = 1'b0;
        @(posedge clk); #1;
        aclr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("late_rsp_st_valid", 32'(st_valid), 32'd0);
            chk("late_rsp_busy", 32'(busy), 32'd0);
        end
        n = 0;
        while (pend_addr.size() > 0 && n < 100) begin
            @(posedge clk); n++;
        end
        chk("late_rsp_drained", 32'(pend_addr.size()), 32'd0);
        lat_mode = 0;
        run("after_reset", 32'h40, 16'd1, 100);

        // address wrap
        run("wrap", 32'hFFFF_FFFC, 16'd2, 100);
        chk("wrap_addr0", issue_log[0], 32'hFFFF_FFFC);
        chk("wrap_addr1", issue_log[1], 32'h0000_0000);

        // randomized transfers: random base, length, stalls, latency, ready
        lat_mode = 1; wr_mode = 1; ready_mode = 2;
        for (int t = 0; t < 8; t++)
            run("random", $urandom, 16'($urandom_range(16, 1)), 2000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
